avs_ocmem_pipelined: RTL

- Parametrised on-chip memory Avalon-MM slave; next generation of the single-port instruction/data OCROM used beside the converter test systems.
- Adds configurable data/address width, pipelined reads with readdatavalid and configurable read latency, waitrequest, write-protect (ROM) mode, and an optional power-on clear FSM.
- Sits directly on the system interconnect as a Nios instruction/data memory or test buffer.

---
 rtl/ocmem_pkg.sv | 19 +
 rtl/ocmem_valid_pipe.sv | 54 +++++
 rtl/avs_ocmem_pipelined.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ocmem_pkg.sv
// ocmem_pkg - shared types and helpers for the pipelined on-chip memory.
//   ocmem_state_e : clear/ready state of the power-on clear FSM
//   byte_parity   : even-parity bit of one byte (1 when the byte has an odd
//                   number of ones, so byte+parity always holds an even count)
//   READ_LAT_MAX  : deepest supported read pipeline
package ocmem_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ocmem_state_e;

   localparam int READ_LAT_MAX = 3;

   function automatic logic byte_parity(input logic [7:0] i_byte);
      return ^i_byte;
   endfunction

endpackage

// File: rtl/ocmem_valid_pipe.sv
// ocmem_valid_pipe - DEPTH-stage read-return pipeline.
//   Carries readdatavalid and the read word through DEPTH registers. Every
//   stage advances only when i_clken=1 and holds otherwise. A data stage
//   loads only when a valid word enters it, so the last-returned word stays
//   on o_data between reads. i_reset_n=0 flushes all stages to zero on the
//   clock edge.
// Ports:
//   clk        clock
//   i_reset_n  synchronous active-low flush
//   i_clken    stage advance enable
//   i_valid    read accepted this cycle
//   i_data     word read from the array for that read
//   o_valid    readdatavalid
//   o_data     readdata (plus any side-band bits)
module ocmem_valid_pipe #(
   parameter int DEPTH  = 1,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              i_reset_n,
   input  logic              i_clken,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid [DEPTH];
   logic [DATA_W-1:0] r_data  [DEPTH];

   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_data[i]  <= '0;
         end
      end else if (i_clken) begin
         r_valid[0] <= i_valid;
         if (i_valid) begin
            r_data[0] <= i_data;
         end
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            if (r_valid[i-1]) begin
               r_data[i] <= r_data[i-1];
            end
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/avs_ocmem_pipelined.sv
// avs_ocmem_pipelined - parametrised on-chip memory, Avalon-MM slave with
// pipelined reads, waitrequest, write protect and optional power-on clear.
// Optional build macro: OCMEM_PARITY_EN (per-byte even parity, sticky
// parity_err output).
//
// Handshake: a transfer is accepted on a rising clk edge where
//   chipselect & (read | write) & ~waitrequest
// holds. The master keeps its request stable while waitrequest=1. Each
// accepted read returns exactly one readdatavalid pulse READ_LAT enabled
// cycles later, in issue order; a cycle with read and write both set is a
// write only.
//
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   address            word address (wraps within ADDR_W bits)
//   byteenable         write byte lanes
//   chipselect         access qualifier
//   read, write        requests (write wins when both set)
//   writedata          write data
//   debugaccess        unlocks writes when ROM_MODE=1
//   clken              clock enable; 0 freezes array, pipeline and FSM
//   reset_req          blocks new accesses, in-flight reads still complete
//   readdata           read data, holds between reads
//   readdatavalid      readdata qualifier
//   waitrequest        back-pressure
//   busy               power-on clear running
//   o_dbg_state        current clear-FSM state (ocmem_state_e encoding)
//   parity_err         sticky parity error (OCMEM_PARITY_EN only)
module avs_ocmem_pipelined
   import ocmem_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 11,
   parameter int READ_LAT       = 1,
   parameter int ROM_MODE       = 1,
   parameter int CLEAR_ON_RESET = 0,
   parameter     INIT_FILE      = ""
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W/8-1:0] byteenable,
   input  logic                chipselect,
   input  logic                read,
   input  logic                write,
   input  logic [DATA_W-1:0]   writedata,
   input  logic                debugaccess,
   input  logic                clken,
   input  logic                reset_req,
   output logic [DATA_W-1:0]   readdata,
   output logic                readdatavalid,
   output logic                waitrequest,
   output logic                busy,
   output logic                o_dbg_state
`ifdef OCMEM_PARITY_EN
   ,
   output logic                parity_err
`endif
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ONE_A = 1;

   if (READ_LAT < 1 || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
      $error("avs_ocmem_pipelined: READ_LAT out of range");
   end
   if ((DATA_W % 8) != 0) begin : g_bad_data_w
      $error("avs_ocmem_pipelined: DATA_W must be a multiple of 8");
   end
   if (INIT_FILE != "") begin : g_init_file
      // Preload content is bound to r_mem by the implementation flow under
      // this block name; the power-on clear overrides it when enabled.
   end

   // ---------------------------------------------------------------- FSM
   ocmem_state_e      r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_nxt;
   logic              w_wait, w_busy;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      w_wait         = 1'b1;
      w_busy         = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            w_busy = 1'b1;
            if (clken) begin
               w_clr_addr_nxt = r_clr_addr + ONE_A;
               if (r_clr_addr == '1) begin
                  w_state_nxt = ST_READY;
               end
            end
         end
         ST_READY: begin
            w_wait = ~clken | reset_req;
         end
         default: ;
      endcase
      // Outputs follow the reset pin directly so the master is held off
      // even in the cycle where reset is first applied.
      if (!reset_n) begin
         w_wait = 1'b1;
         w_busy = (CLEAR_ON_RESET != 0);
      end
   end

   assign waitrequest = w_wait;
   assign busy        = w_busy;
   assign o_dbg_state = r_state;

   // ------------------------------------------------------ access decode
   logic w_accept, w_wr, w_rd, w_wr_en, w_clr_we;

   // waitrequest already covers reset, CLEAR, clken=0 and reset_req.
   assign w_accept = chipselect & (read | write) & ~w_wait;
   assign w_wr     = w_accept & write;
   assign w_rd     = w_accept & read & ~write;
   // Protected writes complete the handshake but never reach the array.
   assign w_wr_en  = w_wr & ((ROM_MODE == 0) | debugaccess);
   assign w_clr_we = reset_n & clken & (r_state == ST_CLEAR);

   // -------------------------------------------------------------- array
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_clr_addr] <= '0;
      end else if (w_wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (byteenable[i]) begin
               r_mem[address][8*i +: 8] <= writedata[8*i +: 8];
            end
         end
      end
   end

`ifdef OCMEM_PARITY_EN
   localparam int PIPE_W = DATA_W + NB;

   logic [NB-1:0] r_par [DEPTH];

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_par[r_clr_addr] <= '0;
      end else if (w_wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (byteenable[i]) begin
               r_par[address][i] <= byte_parity(writedata[8*i +: 8]);
            end
         end
      end
   end
`else
   localparam int PIPE_W = DATA_W;
`endif

   // ---------------------------------------------------- read pipeline
   // The array is sampled before this edge's write lands, so a read that
   // coincides with a write to the same word returns the old content.
   logic [PIPE_W-1:0] w_pipe_in, w_pipe_out;
   logic              w_pipe_valid;

`ifdef OCMEM_PARITY_EN
   assign w_pipe_in = {r_par[address], r_mem[address]};
`else
   assign w_pipe_in = r_mem[address];
`endif

   ocmem_valid_pipe #(
      .DEPTH  (READ_LAT),
      .DATA_W (PIPE_W)
   ) u_valid_pipe (
      .clk       (clk),
      .i_reset_n (reset_n),
      .i_clken   (clken),
      .i_valid   (w_rd),
      .i_data    (w_pipe_in),
      .o_valid   (w_pipe_valid),
      .o_data    (w_pipe_out)
   );

   assign readdata      = w_pipe_out[DATA_W-1:0];
   assign readdatavalid = w_pipe_valid;

`ifdef OCMEM_PARITY_EN
   logic w_par_bad;
   logic r_parity_err;

   always_comb begin
      w_par_bad = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (byte_parity(w_pipe_out[8*i +: 8]) != w_pipe_out[DATA_W+i]) begin
            w_par_bad = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_parity_err <= 1'b0;
      end else if (w_pipe_valid && w_par_bad) begin
         r_parity_err <= 1'b1;
      end
   end

   assign parity_err = r_parity_err;
`endif

endmodule
